// File: rtl/qpp_pkg.sv
// rtl/qpp_pkg.sv - shared state type, width defaults and modular add/subtract helpers for the QPP index generator
package qpp_pkg;

    localparam int QPP_IDX_W_DEFAULT = 13;
    // Helper datapath width; callers zero-extend IDX_W operands (IDX_W < QPP_FW).
    localparam int QPP_FW = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_INIT,
        ST_PREP,
        ST_STREAM
    } qpp_state_t;

    // Operands are < k, so the sum is < 2k and one conditional subtract reduces it.
    function automatic logic [QPP_FW-1:0] mod_add(input logic [QPP_FW-1:0] a,
                                                  input logic [QPP_FW-1:0] b,
                                                  input logic [QPP_FW-1:0] k);
        logic [QPP_FW:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, k}) s = s - {1'b0, k};
        return s[QPP_FW-1:0];
    endfunction

    function automatic logic [QPP_FW-1:0] mod_sub(input logic [QPP_FW-1:0] a,
                                                  input logic [QPP_FW-1:0] b,
                                                  input logic [QPP_FW-1:0] k);
        logic [QPP_FW-1:0] s;
        s = a - b;
        if (a < b) s = s + k;
        return s;
    endfunction

endpackage

// File: rtl/qpp_lane.sv
// rtl/qpp_lane.sv - one output lane: current index and first difference, stepped on each accepted beat
module qpp_lane
    import qpp_pkg::*;
#(
    parameter int IDX_W = QPP_IDX_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] k,
    input  logic             load,
    input  logic [IDX_W-1:0] cur_init,
    input  logic [IDX_W-1:0] d_init,
    input  logic [IDX_W-1:0] dd,
    input  logic             en,
    output logic [IDX_W-1:0] cur
);

    logic [IDX_W-1:0] d;

    function automatic logic [IDX_W-1:0] add_k(input logic [IDX_W-1:0] a,
                                               input logic [IDX_W-1:0] b,
                                               input logic [IDX_W-1:0] m);
        return IDX_W'(mod_add(QPP_FW'(a), QPP_FW'(b), QPP_FW'(m)));
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur <= '0;
            d   <= '0;
        end else if (load) begin
            cur <= cur_init;
            d   <= d_init;
        end else if (en) begin
            cur <= add_k(cur, d, k);
            d   <= add_k(d, dd, k);
        end
    end

endmodule

// File: rtl/qpp_index_gen_par.sv
// rtl/qpp_index_gen_par.sv - multi-lane QPP interleaver index generator; QPP_PARAM_CHECK_EN enables descriptor rejection
module qpp_index_gen_par
    import qpp_pkg::*;
#(
    parameter int LANES = 8,
    parameter int IDX_W = QPP_IDX_W_DEFAULT
) (
    input  logic                   aclk,
    input  logic                   areset,
    input  logic [IDX_W-1:0]       s_axis_k_tdata,
    input  logic [IDX_W-1:0]       s_axis_f1_tdata,
    input  logic [IDX_W-1:0]       s_axis_f2_tdata,
    input  logic                   s_axis_k_tvalid,
    output logic                   s_axis_k_tready,
    output logic [LANES*IDX_W-1:0] m_axis_ind_tdata,
    output logic                   m_axis_ind_tvalid,
    input  logic                   m_axis_ind_tready,
    output logic                   m_axis_ind_tlast,
    output logic                   m_axis_ind_tuser,
    output logic                   cfg_err
);

    localparam int LOG_L = $clog2(LANES);
    localparam int NPI   = 2 * LANES;
    localparam int CW    = (NPI > 2) ? $clog2(NPI) : 1;

    qpp_state_t       state, state_nx;
    logic [IDX_W-1:0] k_r, f1_r, f2_r, g_r, s_r, p_r, last_r, beat_r;
    logic [IDX_W-1:0] p_next, dd;
    logic [IDX_W-1:0] pi_sr [NPI];
    logic [IDX_W-1:0] pi_at [NPI+1];
    logic [CW-1:0]    init_cnt;
    logic             desc_hs, desc_bad, beat_acc;

    function automatic logic [IDX_W-1:0] add_k(input logic [IDX_W-1:0] a,
                                               input logic [IDX_W-1:0] b,
                                               input logic [IDX_W-1:0] m);
        return IDX_W'(mod_add(QPP_FW'(a), QPP_FW'(b), QPP_FW'(m)));
    endfunction

    function automatic logic [IDX_W-1:0] sub_k(input logic [IDX_W-1:0] a,
                                               input logic [IDX_W-1:0] b,
                                               input logic [IDX_W-1:0] m);
        return IDX_W'(mod_sub(QPP_FW'(a), QPP_FW'(b), QPP_FW'(m)));
    endfunction

    assign s_axis_k_tready   = (state == ST_IDLE) && !areset;
    assign m_axis_ind_tvalid = (state == ST_STREAM);
    assign m_axis_ind_tuser  = m_axis_ind_tvalid && (beat_r == '0);
    assign m_axis_ind_tlast  = m_axis_ind_tvalid && (beat_r == last_r);
    assign desc_hs           = s_axis_k_tvalid && s_axis_k_tready;
    assign beat_acc          = m_axis_ind_tvalid && m_axis_ind_tready;
    assign p_next            = add_k(p_r, g_r, k_r);

`ifdef QPP_PARAM_CHECK_EN
    logic cfg_err_r;
    assign desc_bad = (s_axis_k_tdata < IDX_W'(NPI))
                   || ((s_axis_k_tdata & IDX_W'(LANES - 1)) != '0)
                   || (s_axis_f1_tdata >= s_axis_k_tdata)
                   || (s_axis_f2_tdata >= s_axis_k_tdata)
                   || !s_axis_f1_tdata[0];
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) cfg_err_r <= 1'b0;
        else        cfg_err_r <= desc_hs && desc_bad;
    end
    assign cfg_err = cfg_err_r;
`else
    assign desc_bad = 1'b0;
    assign cfg_err  = 1'b0;
`endif

    // pi_sr[j] holds pi(j+1) once INIT completes; pi(0) is always zero.
    always_comb begin
        pi_at[0] = '0;
        for (int j = 0; j < NPI; j++) pi_at[j+1] = pi_sr[j];
    end

    assign dd = sub_k(sub_k(pi_at[NPI], pi_at[LANES], k_r), pi_at[LANES], k_r);

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:   if (desc_hs && !desc_bad) state_nx = ST_LOAD;
            ST_LOAD:   state_nx = ST_INIT;
            ST_INIT:   if (init_cnt == CW'(NPI - 1)) state_nx = ST_PREP;
            // last_r all-ones means K/LANES is zero: nothing to stream.
            ST_PREP:   state_nx = (last_r == '1) ? ST_IDLE : ST_STREAM;
            ST_STREAM: if (beat_acc && (beat_r == last_r)) state_nx = ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state    <= ST_IDLE;
            k_r      <= '0;
            f1_r     <= '0;
            f2_r     <= '0;
            g_r      <= '0;
            s_r      <= '0;
            p_r      <= '0;
            last_r   <= '0;
            beat_r   <= '0;
            init_cnt <= '0;
            for (int j = 0; j < NPI; j++) pi_sr[j] <= '0;
        end else begin
            state <= state_nx;
            case (state)
                ST_IDLE: if (desc_hs) begin
                    k_r  <= s_axis_k_tdata;
                    f1_r <= s_axis_f1_tdata;
                    f2_r <= s_axis_f2_tdata;
                end
                ST_LOAD: begin
                    g_r      <= add_k(f1_r, f2_r, k_r);
                    s_r      <= add_k(f2_r, f2_r, k_r);
                    p_r      <= '0;
                    init_cnt <= '0;
                    beat_r   <= '0;
                    last_r   <= (k_r >> LOG_L) - IDX_W'(1);
                end
                ST_INIT: begin
                    for (int j = 0; j < NPI - 1; j++) pi_sr[j] <= pi_sr[j+1];
                    pi_sr[NPI-1] <= p_next;
                    p_r          <= p_next;
                    g_r          <= add_k(g_r, s_r, k_r);
                    init_cnt     <= init_cnt + CW'(1);
                end
                ST_STREAM: if (beat_acc) beat_r <= beat_r + IDX_W'(1);
                default: ;
            endcase
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [IDX_W-1:0] cur;
        qpp_lane #(.IDX_W(IDX_W)) u_lane (
            .clk      (aclk),
            .rst      (areset),
            .k        (k_r),
            .load     (state == ST_PREP),
            .cur_init (pi_at[l]),
            .d_init   (sub_k(pi_at[l+LANES], pi_at[l], k_r)),
            .dd       (dd),
            .en       (beat_acc),
            .cur      (cur)
        );
        assign m_axis_ind_tdata[l*IDX_W +: IDX_W] = cur;
    end

endmodule
